uart_receiver: RTL

//  UART receive path, 8N1, LSB first, idle-high line; the receive-side counterpart of the

---
 rtl/uart_receiver_if.sv | 39 +++
 rtl/uart_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver_if
// Description : Serial-in / byte-out bundle for the UART receive path.
//               master : drives the serial line, consumes the byte strobes
//               slave  : the receiver (samples RxD, produces data/strobes)
//   RxD          serial input, idle high
//   data         last good byte
//   valid        one-cycle strobe, data updated
//   frame_error  one-cycle strobe, stop bit sampled low
//   busy         receiver FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 RxD;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_error;
    logic                 busy;

    modport master (
        output RxD,
        input  data,
        input  valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  RxD,
        output data,
        output valid,
        output frame_error,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver, LSB first, idle-high line. RxD is
//               synchronised, the start edge is detected on the synchronised
//               line, then every bit is sampled at its middle. A good frame
//               updates data with a one-cycle valid strobe; a low stop bit
//               gives a one-cycle frame_error strobe and the byte is dropped.
// Ports       : clock        system clock
//               reset        synchronous, active-high
//               bus (slave)  RxD in; data / valid / frame_error / busy out
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic       clock,
    input  wire logic       reset,
    uart_receiver_if.slave  bus
);

    localparam int             CNT_W        = 14;
    localparam int             HALF         = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] C_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam int             IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BRK   = 3'd4;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_rx_prev;
    logic                   w_rx_s;
    logic                   w_sync_ready;
    logic                   w_start_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '1;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.RxD};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rx_s       = r_sync[SYNC_STAGES-1];
    // The synchroniser is preset high, so until the real pin level has
    // reached rx_s its output is not trustworthy. rx_prev is held low during
    // that window so a line held low out of reset never looks like a
    // high->low start edge.
    assign w_sync_ready = r_fill[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_prev <= 1'b0;
        end else begin
            r_rx_prev <= w_sync_ready & w_rx_s;
        end
    end

    assign w_start_edge = r_rx_prev & ~w_rx_s;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     r_cnt,   w_cnt_next;
    logic [IDX_W-1:0]     r_idx,   w_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data,  w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_ferr,  w_ferr_next;

    logic w_half_done;
    logic w_bit_done;

    assign w_half_done = (r_cnt == C_HALF_END);
    assign w_bit_done  = (r_cnt == C_BIT_END);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) w_state_next = ST_START;
            end
            ST_START: begin
                // A line back high at mid start bit is treated as a glitch.
                if (w_half_done) w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_done && (r_idx == C_IDX_LAST)) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Leaving at mid stop bit lets a following start edge be
                // caught with no inter-frame gap.
                if (w_bit_done) w_state_next = w_rx_s ? ST_IDLE : ST_BRK;
            end
            ST_BRK: begin
                if (w_rx_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath control logic
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_idx_next = '0;
            end
            ST_START: begin
                w_cnt_next = w_half_done ? '0 : r_cnt + CNT_W'(1);
                w_idx_next = '0;
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_idx_next   = r_idx + IDX_W'(1);
                    // LSB arrives first, so shifting right leaves it at bit 0.
                    w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                    end else begin
                        w_ferr_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_BRK: begin
                w_cnt_next = '0;
            end
            default: begin
                w_cnt_next = '0;
                w_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_ferr_next;
        end
    end

    assign bus.data        = r_data;
    assign bus.valid       = r_valid;
    assign bus.frame_error = r_ferr;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
